// File: rtl/jtdd_char_romslot_pkg.sv
// ----------------------------------------------------------------------------
// jtdd_char_romslot_pkg
// Shared definitions for the character ROM slot: FSM state encoding and the
// SDRAM handshake data width. The ROM slots for the object and scroll layers
// use the same handshake, so these definitions live here rather than in the
// slot itself.
// ----------------------------------------------------------------------------
package jtdd_char_romslot_pkg;

    // SDRAM handshake widths
    localparam int SDRAM_DW     = 16;   // SDRAM data word width
    localparam int SDRAM_AW_DEF = 22;   // default SDRAM word-address width

    // Fetch FSM states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_DATA = 2'd2
    } romslot_state_t;

endpackage

// File: rtl/jtdd_char_romslot.sv
// ----------------------------------------------------------------------------
// jtdd_char_romslot
// ROM-side responder for the character layer's graphics fetch port. Keeps a
// single 16-bit word cache tagged by the client word address. Hits are answered
// combinationally in the same cycle; misses start a req/ack/data_rdy fetch from
// the SDRAM controller. At most one fetch is outstanding, and a fetch is never
// aborted: if the client moves on, the fetch still fills the cache and IDLE
// re-evaluates the new address afterwards.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous reset, active low
//   addr        client byte address
//   addr_ok     client address valid
//   dout        selected byte of the cached word
//   data_ok     dout is valid for the current addr (cache hit)
//   sdram_addr  registered SDRAM word address (OFFSET + word address, wraps)
//   sdram_req   fetch request level, held until sdram_ack
//   sdram_ack   one-cycle pulse: request accepted
//   data_rdy    one-cycle pulse: data_read valid
//   data_read   SDRAM data word
// ----------------------------------------------------------------------------
module jtdd_char_romslot
    import jtdd_char_romslot_pkg::*;
#(
    parameter int             AW     = 15,
    parameter int             SDW    = SDRAM_AW_DEF,
    parameter logic [SDW-1:0] OFFSET = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [AW-1:0]       addr,
    input  logic                addr_ok,
    output logic [7:0]          dout,
    output logic                data_ok,
    output logic [SDW-1:0]      sdram_addr,
    output logic                sdram_req,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [SDRAM_DW-1:0] data_read
);

    localparam int TW = AW - 1;     // word-address (tag) width

    romslot_state_t      state_q;
    logic [TW-1:0]       req_tag_q;
    logic [TW-1:0]       tag_q;
    logic                valid_q;
    logic [SDRAM_DW-1:0] cache_q;
    logic [SDW-1:0]      sdram_addr_q;
    logic                sdram_req_q;

    logic [TW-1:0]       addr_tag;
    logic                hit;
    logic [SDW-1:0]      sdram_addr_d;

    assign addr_tag = addr[AW-1:1];
    assign hit      = valid_q && (tag_q == addr_tag) && addr_ok;

    // Region base plus word address; the sum is truncated to SDW bits so an
    // offset near the top of the address space wraps around silently.
    assign sdram_addr_d = OFFSET + SDW'(addr_tag);

    // Hit path is purely combinational from the cache registers.
    assign data_ok    = hit;
    assign dout       = addr[0] ? cache_q[15:8] : cache_q[7:0];
    assign sdram_addr = sdram_addr_q;
    assign sdram_req  = sdram_req_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_tag_q    <= '0;
            tag_q        <= '0;
            valid_q      <= 1'b0;
            cache_q      <= '0;
            sdram_addr_q <= '0;
            sdram_req_q  <= 1'b0;
        end else begin
            case (state_q)
                // ack/data_rdy are deliberately ignored here so stray pulses
                // (e.g. from a request withdrawn by reset) cannot fill the cache.
                ST_IDLE: begin
                    if (addr_ok && !hit) begin
                        req_tag_q    <= addr_tag;
                        sdram_addr_q <= sdram_addr_d;
                        sdram_req_q  <= 1'b1;
                        state_q      <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (sdram_ack) begin
                        sdram_req_q <= 1'b0;
                        if (data_rdy) begin
                            // Controller delivered data with the ack: fill now.
                            cache_q <= data_read;
                            tag_q   <= req_tag_q;
                            valid_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_WAIT_DATA;
                        end
                    end
                end
                ST_WAIT_DATA: begin
                    if (data_rdy) begin
                        cache_q <= data_read;
                        tag_q   <= req_tag_q;
                        valid_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    sdram_req_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
